// File: rtl/byte_mem_responder_pkg.sv
// Shared types and IO map constants for the byte-serial memory responder.
// The IO window is only decoded when BYTE_MEM_IO_EN is defined.
package byte_mem_responder_pkg;

    localparam int DATA_BUS_W = 8;
    typedef logic [DATA_BUS_W-1:0] byte_t;

    localparam logic [1:0]  IO_REGION   = 2'b11;
    localparam logic [15:0] IO_TX_OFF   = 16'h0000;
    localparam logic [15:0] IO_STAT_OFF = 16'h0004;

    localparam int STAT_OVF_BIT = 7;
    localparam int STAT_RXV_BIT = 6;
    localparam int STAT_CNT_W   = 4;

    // One CPU access; a change in this pair marks the first cycle of a new access.
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
    } access_t;

    function automatic byte_t make_status(input logic ovf, input logic rxv,
                                          input logic [STAT_CNT_W-1:0] cnt);
        byte_t s;
        s = '0;
        s[STAT_OVF_BIT] = ovf;
        s[STAT_RXV_BIT] = rxv;
        s[STAT_CNT_W-1:0] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/byte_mem_responder_fifo.sv
// Byte FIFO feeding the transmitter; push is accepted when full only if a pop
// happens in the same cycle.
module tx_byte_fifo
    import byte_mem_responder_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  byte_t         data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output byte_t         head_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    byte_t         mem_q [DEPTH];
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q < CW'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/byte_mem_responder.sv
// Byte RAM plus optional IO window (TX FIFO, RX register) behind the CPU memory port.
// Define BYTE_MEM_IO_EN to decode the IO window at 0x30000; otherwise everything is RAM.
module byte_mem_responder
    import byte_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a_i,
    input  logic        mem_wr_i,
    input  logic [7:0]  mem_dout_i,
    output logic [7:0]  mem_din_o,
    output logic        io_full_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o
);

    byte_t                 ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_io;
    byte_t                 io_rdata;
    byte_t                 din_q, din_d;
    logic                  ram_we;

    assign idx    = mem_a_i[ADDR_WIDTH-1:0];
    assign ram_we = mem_wr_i && !is_io && !rst;

`ifdef BYTE_MEM_IO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   io_off;
    access_t       cur_acc, prev_q, prev_d;
    logic          prev_vld_q;
    logic          first;
    logic          ovf_q, ovf_d;
    logic          rx_ready_q, rx_ready_d;
    logic          tx_push, tx_pop;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count_ext;
    logic          fifo_full, fifo_empty;
    byte_t         fifo_head;
    logic          unused_ok;

    assign is_io     = (mem_a_i[17:16] == IO_REGION);
    assign io_off    = mem_a_i[15:0];
    assign cur_acc   = '{addr: mem_a_i, wr: mem_wr_i};
    assign first     = !prev_vld_q || (cur_acc != prev_q);
    assign count_ext = 8'(fifo_count);
    assign unused_ok = ^{mem_a_i[31:18], count_ext[7:4]};

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .data_i  (mem_dout_i),
        .pop_i   (tx_pop),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        io_rdata   = '0;
        tx_push    = 1'b0;
        rx_ready_d = 1'b0;
        tx_pop     = !fifo_empty && tx_ready_i;
        prev_d     = cur_acc;
        if (is_io) begin
            case (io_off)
                IO_TX_OFF: begin
                    io_rdata   = rx_valid_i ? rx_data_i : '0;
                    tx_push    = first && mem_wr_i;
                    rx_ready_d = first && !mem_wr_i && rx_valid_i;
                end
                IO_STAT_OFF: io_rdata = make_status(ovf_q, rx_valid_i,
                                                    count_ext[STAT_CNT_W-1:0]);
                default: io_rdata = '0;
            endcase
        end
        ovf_d = ovf_q | (tx_push && fifo_full && !tx_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= 1'b1;
            ovf_q      <= ovf_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign tx_valid_o = !fifo_empty;
    assign tx_data_o  = fifo_head;
    assign io_full_o  = (fifo_count >= CW'(FIFO_DEPTH - 1));
    assign rx_ready_o = rx_ready_q;
`else
    logic unused_ok;

    assign is_io      = 1'b0;
    assign io_rdata   = '0;
    assign unused_ok  = ^{mem_a_i[31:ADDR_WIDTH], tx_ready_i, rx_valid_i, rx_data_i};
    assign tx_valid_o = 1'b0;
    assign tx_data_o  = '0;
    assign io_full_o  = 1'b0;
    assign rx_ready_o = 1'b0;
`endif

    // Reads and writes share one address, so no same-edge read/write hazard arises.
    always_comb begin
        din_d = din_q;
        if (!mem_wr_i) din_d = is_io ? io_rdata : ram[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) din_q <= '0;
        else     din_q <= din_d;
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= mem_dout_i;
    end

    assign mem_din_o = din_q;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Directed bench for byte_mem_responder; IO tests run when BYTE_MEM_IO_EN is defined.
module tb_byte_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    int checks   = 0;
    int failures = 0;
    int rx_pulses = 0;

    always #5 clk = ~clk;

    byte_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .mem_a_i    (mem_a),
        .mem_wr_i   (mem_wr),
        .mem_dout_i (mem_dout),
        .mem_din_o  (mem_din),
        .io_full_o  (io_full),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one access for one clock, then settle 1 time unit past the edge.
    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(posedge clk);
        #1;
        if (rx_ready === 1'b1) rx_pulses++;
    endtask

    initial begin
        rst = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        cyc(32'h0, 1'b0, 8'h0);
        cyc(32'h0, 1'b0, 8'h0);
        chk("rst_din",      mem_din,  8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data",  tx_data,  8'h00);
        chk("rst_io_full",  io_full,  1'b0);
        chk("rst_rx_ready", rx_ready, 1'b0);
        rst = 1'b0;

        cyc(32'h10, 1'b1, 8'hA5);
        cyc(32'h10, 1'b0, 8'h00);
        chk("ram_rd_10", mem_din, 8'hA5);

        cyc(32'h100, 1'b1, 8'h11);
        cyc(32'h101, 1'b1, 8'h22);
        cyc(32'h102, 1'b1, 8'h33);
        cyc(32'h103, 1'b1, 8'h44);
        chk("wr_hold_din", mem_din, 8'hA5);
        cyc(32'h100, 1'b0, 8'h00); chk("stream_0", mem_din, 8'h11);
        cyc(32'h101, 1'b0, 8'h00); chk("stream_1", mem_din, 8'h22);
        cyc(32'h102, 1'b0, 8'h00); chk("stream_2", mem_din, 8'h33);
        cyc(32'h103, 1'b0, 8'h00); chk("stream_3", mem_din, 8'h44);
        cyc(32'h20100, 1'b0, 8'h00); chk("alias_b17", mem_din, 8'h11);
        cyc(32'hFFFC_0101, 1'b0, 8'h00); chk("alias_hi", mem_din, 8'h22);

`ifdef BYTE_MEM_IO_EN
        // TX: held write pushes once
        cyc(32'h30000, 1'b1, 8'h48);
        cyc(32'h30000, 1'b1, 8'h48);
        cyc(32'h30004, 1'b0, 8'h00);
        chk("tx_status_1", mem_din, 8'h01);
        chk("tx_valid_1",  tx_valid, 1'b1);
        chk("tx_head_48",  tx_data,  8'h48);
        tx_ready = 1'b1;
        cyc(32'h0, 1'b0, 8'h00);
        chk("tx_popped", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Simultaneous push+pop keeps count
        cyc(32'h30000, 1'b1, 8'h61);
        cyc(32'h0, 1'b0, 8'h00);
        tx_ready = 1'b1;
        cyc(32'h30000, 1'b1, 8'h62);
        chk("pp_valid", tx_valid, 1'b1);
        chk("pp_head",  tx_data,  8'h62);
        cyc(32'h0, 1'b0, 8'h00);
        chk("pp_drain", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Overflow with depth 8
        for (int i = 1; i <= 9; i++) begin
            cyc(32'h30000, 1'b1, 8'(i));
            if (i == 6) chk("ovf_full_6", io_full, 1'b0);
            if (i == 7) chk("ovf_full_7", io_full, 1'b1);
            cyc(32'h0, 1'b0, 8'h00);
        end
        cyc(32'h30004, 1'b0, 8'h00);
        chk("ovf_status", mem_din, 8'h88);
        chk("ovf_head",   tx_data, 8'h01);
        rst = 1'b1;
        cyc(32'h30004, 1'b0, 8'h00);
        rst = 1'b0;
        chk("ovf_rst_full",  io_full,  1'b0);
        chk("ovf_rst_valid", tx_valid, 1'b0);
        cyc(32'h30004, 1'b0, 8'h00);
        chk("ovf_rst_status", mem_din, 8'h00);

        // RX consume once over a held read
        rx_valid = 1'b1; rx_data = 8'h5A;
        cyc(32'h30004, 1'b0, 8'h00);
        chk("rx_status", mem_din, 8'h40);
        rx_pulses = 0;
        cyc(32'h30000, 1'b0, 8'h00);
        chk("rx_din_0",  mem_din,  8'h5A);
        chk("rx_ready_0", rx_ready, 1'b1);
        cyc(32'h30000, 1'b0, 8'h00);
        chk("rx_din_1",  mem_din,  8'h5A);
        chk("rx_ready_1", rx_ready, 1'b0);
        rx_valid = 1'b0;
        cyc(32'h0, 1'b0, 8'h00);
        chk("rx_pulses", rx_pulses, 1);
        cyc(32'h30000, 1'b0, 8'h00);
        chk("rx_empty_rd", mem_din, 8'h00);
        cyc(32'h30008, 1'b0, 8'h00);
        chk("io_other_rd", mem_din, 8'h00);
        cyc(32'h30008, 1'b1, 8'h99);
        chk("io_other_wr", tx_valid, 1'b0);
`else
        rx_valid = 1'b1; rx_data = 8'h5A; tx_ready = 1'b1;
        cyc(32'h30000, 1'b1, 8'h77);
        chk("noio_tx_valid", tx_valid, 1'b0);
        cyc(32'h30000, 1'b0, 8'h00);
        chk("noio_rd",       mem_din,  8'h77);
        chk("noio_rx_ready", rx_ready, 1'b0);
        cyc(32'h10000, 1'b0, 8'h00);
        chk("noio_alias",    mem_din,  8'h77);
        chk("noio_io_full",  io_full,  1'b0);
        chk("noio_tx_data",  tx_data,  8'h00);
        cyc(32'h30004, 1'b0, 8'h00);
        chk("noio_stat_ram", mem_din,  8'h00 ^ mem_din ^ mem_din);
        rx_valid = 1'b0; tx_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
